decode_issue_ctrl: RTL and testbench

//  Sequences instructions from fetch into the combinational instruction decoder.

---
 rtl/decode_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_decode_issue_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// Decode issue controller: buffers fetched {addr,instr} pairs, presents the head to the
// decoder, hands it to rename, and serializes SYSTEM instructions behind an empty ROB.
module decode_issue_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int DRAIN_DELAY = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            if_valid,
  output logic                            if_ready,
  input  logic [ADDR_WIDTH-1:0]           if_instr_addr,
  input  logic [DATA_WIDTH-1:0]           if_instr,
  output logic [ADDR_WIDTH-1:0]           dec_instr_addr,
  output logic [DATA_WIDTH-1:0]           dec_instr,
  output logic                            dec_valid,
  input  logic                            rn_ready,
  input  logic                            rob_empty,
  output logic [$clog2(FIFO_DEPTH):0]     occupancy,
  output logic [1:0]                      sys_state
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int DRAIN_W = $clog2(DRAIN_DELAY + 1);
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_C = DRAIN_W'(DRAIN_DELAY);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SYS_WAIT  = 2'd1,
    SYS_DRAIN = 2'd2
  } state_e;

  logic [ADDR_WIDTH-1:0] addr_mem_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  state_e                state_q, state_d;

  logic push, pop, not_empty, is_sys;

  assign not_empty      = (count_q != '0);
  assign if_ready       = !rst && !flush && (count_q < DEPTH_C);
  assign push           = if_valid && if_ready && !flush;
  assign pop            = dec_valid && rn_ready;
  assign dec_instr_addr = not_empty ? addr_mem_q[rd_ptr_q]  : '0;
  assign dec_instr      = not_empty ? instr_mem_q[rd_ptr_q] : '0;
  assign is_sys         = not_empty && (dec_instr[6:0] == 7'b1110011);
  assign occupancy      = count_q;
  assign sys_state      = state_q;

  // Storage carries no reset; entries are only ever read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q]  <= if_instr_addr;
      instr_mem_q[wr_ptr_q] <= if_instr;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // dec_valid is gated by flush so that no rename handshake can happen in a redirect cycle.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    dec_valid = 1'b0;
    case (state_q)
      RUN: begin
        dec_valid = not_empty && (!is_sys || rob_empty);
        if (is_sys && !rob_empty) begin
          state_d = SYS_WAIT;
        end else if (pop && is_sys) begin
          state_d = SYS_DRAIN;
          drain_d = DRAIN_C;
        end
      end
      SYS_WAIT: begin
        dec_valid = not_empty && rob_empty;
        if (pop) begin
          state_d = SYS_DRAIN;
          drain_d = DRAIN_C;
        end
      end
      SYS_DRAIN: begin
        if (drain_q != '0) drain_d = drain_q - 1'b1;
        if (drain_q == '0 && rob_empty) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (rst || flush) begin
      dec_valid = 1'b0;
      state_d   = RUN;
      drain_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drain_q  <= '0;
      state_q  <= RUN;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drain_q  <= drain_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: per-cycle vector table for FIFO behaviour, hand sequences for
// SYSTEM serialization and flush, and a scoreboard queue that checks issue order and data.
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, ifValid, rnReady, robEmpty;
  logic        if_ready, dec_valid;
  logic [31:0] ifInstrAddr, ifInstr, dec_instr_addr, dec_instr;
  logic [2:0]  occupancy;
  logic [1:0]  sys_state;

  int checkCount = 0;
  int errorCount = 0;
  logic [63:0] sbQ[$];

  typedef struct {
    logic        ifValid;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        rnReady;
    logic        robEmpty;
    logic        flush;
    logic        expIfReady;
    logic        expDecValid;
    logic [2:0]  expOcc;
    logic [1:0]  expState;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  decode_issue_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .DRAIN_DELAY(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(ifValid), .if_ready(if_ready),
    .if_instr_addr(ifInstrAddr), .if_instr(ifInstr),
    .dec_instr_addr(dec_instr_addr), .dec_instr(dec_instr), .dec_valid(dec_valid),
    .rn_ready(rnReady), .rob_empty(robEmpty),
    .occupancy(occupancy), .sys_state(sys_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addi(input logic [31:0] a);
    return {a[11:0], 20'h00013};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] a, input logic [31:0] ins,
                              input logic rn, input logic rob, input logic fl,
                              input logic eIr, input logic eDv, input logic [2:0] eOcc,
                              input logic [1:0] eSt);
    vec_t v;
    v.ifValid = iv; v.addr = a; v.instr = ins; v.rnReady = rn; v.robEmpty = rob;
    v.flush = fl; v.expIfReady = eIr; v.expDecValid = eDv; v.expOcc = eOcc; v.expState = eSt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ifValid     = v.ifValid;
    ifInstrAddr = v.addr;
    ifInstr     = v.instr;
    rnReady     = v.rnReady;
    robEmpty    = v.robEmpty;
    flush       = v.flush;
  endtask

  // Drive one cycle, check combinational outputs at the falling edge, then run the scoreboard.
  task automatic runVec(input vec_t v, input string tag);
    logic [63:0] exp;
    applyStimulus(v);
    @(negedge clk);
    checkOutput({tag, ".if_ready"},  32'(if_ready),  32'(v.expIfReady));
    checkOutput({tag, ".dec_valid"}, 32'(dec_valid), 32'(v.expDecValid));
    checkOutput({tag, ".occupancy"}, 32'(occupancy), 32'(v.expOcc));
    checkOutput({tag, ".sys_state"}, 32'(sys_state), 32'(v.expState));
    if (v.expOcc == 3'd0) begin
      checkOutput({tag, ".empty_addr"},  dec_instr_addr, 32'h0);
      checkOutput({tag, ".empty_instr"}, dec_instr,      32'h0);
    end
    if (dec_valid && rnReady) begin
      if (sbQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL %s.issue: got unexpected issue of %h expected none", tag, dec_instr_addr);
      end else begin
        exp = sbQ.pop_front();
        checkOutput({tag, ".issue_addr"},  dec_instr_addr, exp[63:32]);
        checkOutput({tag, ".issue_instr"}, dec_instr,      exp[31:0]);
      end
    end
    if (ifValid && if_ready && !flush) sbQ.push_back({ifInstrAddr, ifInstr});
    if (flush) sbQ.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ifValid = 1'b0; rnReady = 1'b0; robEmpty = 1'b1;
    ifInstrAddr = '0; ifInstr = '0;

    // Back-to-back issue, then fill to full with a held fifth fetch, then drain while full.
    vecs.push_back(mk(1, 32'h0, addi(32'h0), 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4, addi(32'h4), 1, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 32'h8, addi(32'h8), 1, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0,       1, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0,       1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0,  addi(32'h0),  0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4,  addi(32'h4),  0, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 32'h8,  addi(32'h8),  0, 1, 0, 1, 1, 2, 0));
    vecs.push_back(mk(1, 32'hC,  addi(32'hC),  0, 1, 0, 1, 1, 3, 0));
    vecs.push_back(mk(1, 32'h10, addi(32'h10), 0, 1, 0, 0, 1, 4, 0));
    vecs.push_back(mk(1, 32'h10, addi(32'h10), 0, 1, 0, 0, 1, 4, 0));
    vecs.push_back(mk(1, 32'h10, addi(32'h10), 1, 1, 0, 0, 1, 4, 0));
    vecs.push_back(mk(1, 32'h10, addi(32'h10), 1, 1, 0, 1, 1, 3, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 1, 3, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 1, 2, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 0, 0, 0));

    repeat (2) begin
      @(negedge clk);
      checkOutput("rst.if_ready",  32'(if_ready),  32'h0);
      checkOutput("rst.dec_valid", 32'(dec_valid), 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) runVec(vecs[i], $sformatf("fifo[%0d]", i));

    // ECALL waits for an empty ROB, then the following addi waits out the drain.
    runVec(mk(1, 32'h100, ECALL,         1, 0, 0, 1, 0, 0, 0), "sys.s0");
    runVec(mk(1, 32'h104, addi(32'h104), 1, 0, 0, 1, 0, 1, 0), "sys.s1");
    runVec(mk(0, 32'h0, 32'h0, 1, 0, 0, 1, 0, 2, 1), "sys.s2");
    runVec(mk(0, 32'h0, 32'h0, 1, 0, 0, 1, 0, 2, 1), "sys.s3");
    runVec(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 1, 2, 1), "sys.s4");
    runVec(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 0, 1, 2), "sys.s5");
    runVec(mk(0, 32'h0, 32'h0, 1, 0, 0, 1, 0, 1, 2), "sys.s6");
    runVec(mk(0, 32'h0, 32'h0, 1, 0, 0, 1, 0, 1, 2), "sys.s7");
    runVec(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 0, 1, 2), "sys.s8");
    runVec(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 1, 1, 0), "sys.s9");
    runVec(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 0, 0, 0), "sys.s10");

    // Flush with three queued entries and a concurrent fetch; only the later 0x300 may issue.
    runVec(mk(1, 32'h200, addi(32'h200), 0, 1, 0, 1, 0, 0, 0), "flush.f0");
    runVec(mk(1, 32'h204, addi(32'h204), 0, 1, 0, 1, 1, 1, 0), "flush.f1");
    runVec(mk(1, 32'h208, addi(32'h208), 0, 1, 0, 1, 1, 2, 0), "flush.f2");
    runVec(mk(1, 32'h20C, addi(32'h20C), 1, 1, 1, 0, 0, 3, 0), "flush.f3");
    runVec(mk(0, 32'h0, 32'h0,           0, 1, 0, 1, 0, 0, 0), "flush.f4");
    runVec(mk(1, 32'h300, addi(32'h300), 1, 1, 0, 1, 0, 0, 0), "flush.f5");
    runVec(mk(0, 32'h0, 32'h0,           1, 1, 0, 1, 1, 1, 0), "flush.f6");
    runVec(mk(0, 32'h0, 32'h0,           1, 1, 0, 1, 0, 0, 0), "flush.f7");

    // Flush in the middle of a drain must cancel the remaining drain cycles.
    runVec(mk(1, 32'h400, EBREAK,       1, 1, 0, 1, 0, 0, 0), "drainfl.g0");
    runVec(mk(0, 32'h0, 32'h0,          1, 1, 0, 1, 1, 1, 0), "drainfl.g1");
    runVec(mk(0, 32'h0, 32'h0,          1, 1, 0, 1, 0, 0, 2), "drainfl.g2");
    runVec(mk(0, 32'h0, 32'h0,          1, 1, 1, 0, 0, 0, 2), "drainfl.g3");
    runVec(mk(1, 32'h40, addi(32'h40),  1, 1, 0, 1, 0, 0, 0), "drainfl.g4");
    runVec(mk(0, 32'h0, 32'h0,          1, 1, 0, 1, 1, 1, 0), "drainfl.g5");
    runVec(mk(0, 32'h0, 32'h0,          1, 1, 0, 1, 0, 0, 0), "drainfl.g6");

    // Reset with a non-empty buffer empties it.
    runVec(mk(1, 32'h500, addi(32'h500), 0, 1, 0, 1, 0, 0, 0), "rst2.h0");
    runVec(mk(0, 32'h0, 32'h0,           0, 1, 0, 1, 1, 1, 0), "rst2.h1");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst2.if_ready",  32'(if_ready),  32'h0);
    checkOutput("rst2.dec_valid", 32'(dec_valid), 32'h0);
    sbQ.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    runVec(mk(0, 32'h0, 32'h0, 1, 1, 0, 1, 0, 0, 0), "rst2.h2");

    checkOutput("scoreboard.leftover", 32'(sbQ.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
